// File: rtl/latq_bank_wr_arb.sv
// Two-requester write arbiter for a bank of level-sensitive latch words.
// Each write runs IDLE -> SETUP -> OPEN -> HOLD so data meets latch setup/hold around one E pulse.
module latq_bank_wr_arb #(
   parameter int unsigned DW = 8,
   parameter int unsigned NW = 8,
   parameter int unsigned AW = 3
) (
   input  logic          clk,
   input  logic          rn,
   input  logic          req0,
   input  logic          req1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wd0,
   input  logic [DW-1:0] wd1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] ld,
   output logic [NW-1:0] le,
   output logic          busy
);

   typedef enum logic [1:0] {StIdle, StSetup, StOpen, StHold} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] ld_q, ld_d;
   logic [NW-1:0] le_q, le_d;
   logic          last_q, last_d;
   logic          gnt_q, gnt_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          busy_q, busy_d;
   logic          grant;

   // Round-robin: on contention favour whoever was not served last.
   assign grant = (req0 & req1) ? ~last_q : req1;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ld_d    = ld_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      le_d    = '0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req0 | req1) begin
               gnt_d   = grant;
               last_d  = grant;
               addr_d  = grant ? addr1 : addr0;
               ld_d    = grant ? wd1 : wd0;
               state_d = StSetup;
            end
         end
         StSetup: begin
            state_d = StOpen;
            // Out-of-range addresses match no bit, so the write completes silently.
            for (int unsigned i = 0; i < NW; i++) begin
               le_d[i] = (addr_q == AW'(i));
            end
         end
         StOpen: begin
            state_d = StHold;
            ack0_d  = ~gnt_q;
            ack1_d  = gnt_q;
         end
         StHold: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         state_q <= StIdle;
         addr_q  <= '0;
         ld_q    <= '0;
         le_q    <= '0;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         ld_q    <= ld_d;
         le_q    <= le_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         busy_q  <= busy_d;
      end
   end

   assign ld   = ld_q;
   assign le   = le_q;
   assign ack0 = ack0_q;
   assign ack1 = ack1_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_latq_bank_wr_arb.sv
// Bench for latq_bank_wr_arb: directed scenarios then random traffic against a
// transaction-level model (phase counter per write) plus a behavioural latch bank.
module tb_latq_bank_wr_arb;

   localparam int unsigned DW = 8;
   localparam int unsigned NW = 6;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          rn;
   logic          req0, req1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wd0, wd1;
   logic          ack0, ack1;
   logic [DW-1:0] ld;
   logic [NW-1:0] le;
   logic          busy;

   latq_bank_wr_arb #(.DW(DW), .NW(NW), .AW(AW)) dut (
      .clk   (clk),
      .rn    (rn),
      .req0  (req0),
      .req1  (req1),
      .addr0 (addr0),
      .addr1 (addr1),
      .wd0   (wd0),
      .wd1   (wd1),
      .ack0  (ack0),
      .ack1  (ack1),
      .ld    (ld),
      .le    (le),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: phase 0 idle, 1..3 are the cycles after grant; the ack lands in phase 3.
   int            m_phase;
   int            m_gnt;
   int            m_addr;
   int            m_last;
   logic [DW-1:0] m_data;
   logic [DW-1:0] lat [NW];
   int            ack_seq [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_phase = 0;
      m_gnt   = 0;
      m_addr  = 0;
      m_last  = 1;
      m_data  = '0;
   endfunction

   function automatic void model_step();
      if (m_phase == 0) begin
         if (req0 || req1) begin
            m_gnt   = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
            m_last  = m_gnt;
            m_addr  = m_gnt ? int'(addr1) : int'(addr0);
            m_data  = m_gnt ? wd1 : wd0;
            m_phase = 1;
         end
      end else begin
         m_phase = (m_phase + 1) % 4;
      end
   endfunction

   task automatic check_outputs();
      logic [31:0] exp_le;
      exp_le = '0;
      if (m_phase == 2 && m_addr < int'(NW)) exp_le = 32'(1) << m_addr;
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("le", 32'(le), exp_le);
      check("ld", 32'(ld), 32'(m_data));
      check("ack0", 32'(ack0), 32'(m_phase == 3 && m_gnt == 0));
      check("ack1", 32'(ack1), 32'(m_phase == 3 && m_gnt == 1));
      check("le_onehot0", 32'($countones(le) <= 1), 32'(1));
      check("ack_excl", 32'(ack0 & ack1), 32'(0));
      for (int i = 0; i < int'(NW); i++) begin
         if (le[i]) lat[i] = ld;
      end
      if (m_phase == 3 && m_addr < int'(NW)) check("latch_q", 32'(lat[m_addr]), 32'(m_data));
      if (ack0) ack_seq.push_back(0);
      if (ack1) ack_seq.push_back(1);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   // Called at a negedge; pulses reset between clock edges and checks the async clear.
   task automatic reset_async();
      #2 rn = 1'b0;
      #1;
      model_reset();
      check_outputs();
      #1 rn = 1'b1;
   endtask

   task automatic drive_random(input bit is_one);
      logic          r;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      r = is_one ? req1 : req0;
      a = is_one ? addr1 : addr0;
      d = is_one ? wd1 : wd0;
      if (m_phase != 0 && m_gnt == int'(is_one)) begin
         // Already captured: changing data or dropping req must not disturb the write.
         if ($urandom_range(3) == 0) d = DW'($urandom);
         if ($urandom_range(7) == 0) r = 1'b0;
      end else if (!r) begin
         if ($urandom_range(1) == 0) begin
            r = 1'b1;
            a = AW'($urandom_range(7));
            d = DW'($urandom);
         end
      end else if ($urandom_range(7) == 0) begin
         r = 1'b0;
      end
      if (is_one) begin
         req1 = r; addr1 = a; wd1 = d;
      end else begin
         req0 = r; addr0 = a; wd0 = d;
      end
   endtask

   initial begin
      rn = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      addr0 = '0; addr1 = '0;
      wd0 = '0; wd1 = '0;
      for (int i = 0; i < int'(NW); i++) lat[i] = '0;
      model_reset();
      @(negedge clk);
      check_outputs();
      @(negedge clk);
      rn = 1'b1;

      // Single write to word 2.
      req0 = 1'b1; addr0 = 3'd2; wd0 = 8'hA5;
      tick();
      check("w1_setup_ld", 32'(ld), 32'h0000_00A5);
      tick();
      check("w1_open_le", 32'(le), 32'h0000_0004);
      tick();
      check("w1_hold_ack0", 32'(ack0), 32'(1));
      req0 = 1'b0;
      tick();

      // Data changes after grant must not reach the bus.
      req0 = 1'b1; addr0 = 3'd5; wd0 = 8'h3C;
      tick();
      wd0 = 8'hC3;
      tick();
      tick();
      check("hold_ld", 32'(ld), 32'h0000_003C);
      req0 = 1'b0;
      tick();

      // Contention straight out of reset: 0,1,0,1.
      req0 = 1'b1; addr0 = 3'd1; wd0 = 8'h11;
      req1 = 1'b1; addr1 = 3'd4; wd1 = 8'h44;
      reset_async();
      ack_seq.delete();
      repeat (16) tick();
      check("rr_count", 32'(ack_seq.size()), 32'(4));
      for (int i = 0; i < 4 && i < ack_seq.size(); i++) begin
         check("rr_order", 32'(ack_seq[i]), 32'(i % 2));
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();

      // Out-of-range word 7 with NW=6.
      req1 = 1'b1; addr1 = 3'd7; wd1 = 8'h77;
      tick();
      tick();
      check("oor_open_le", 32'(le), 32'(0));
      tick();
      check("oor_ack1", 32'(ack1), 32'(1));
      req1 = 1'b0;
      tick();

      // Reset during OPEN, then pending request re-granted on first edge.
      req0 = 1'b1; addr0 = 3'd3; wd0 = 8'h5A;
      tick();
      tick();
      check("rst_open_le", 32'(le), 32'h0000_0008);
      reset_async();
      check("rst_le_async", 32'(le), 32'(0));
      check("rst_busy_async", 32'(busy), 32'(0));
      tick();
      check("regrant_busy", 32'(busy), 32'(1));
      check("regrant_ld", 32'(ld), 32'h0000_005A);
      tick();
      tick();
      req0 = 1'b0;
      tick();

      // Random traffic with occasional mid-sequence resets.
      for (int c = 0; c < 3000; c++) begin
         drive_random(1'b0);
         drive_random(1'b1);
         if ($urandom_range(199) == 0) reset_async();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/latq_bank_wr_arb.md
LATQ_BANK_WR_ARB -- requirements
Module: latq_bank_wr_arb

Interface
REQ-001 Parameter DW, default 8: data width of the latch bank word.
REQ-002 Parameter NW, default 8: number of latch words in the bank.
REQ-003 Parameter AW, default 3: address width; NW SHALL be less than or equal to 2**AW.
REQ-004 CLK  input  1  single clock; all flops SHALL be rising-edge.
REQ-005 RN  input  1  reset; asynchronous, active-low.
REQ-006 REQ0, REQ1  input  1 each  write request from requester 0 and requester 1.
REQ-007 ADDR0, ADDR1  input  AW each  target word of each requester.
REQ-008 WD0, WD1  input  DW each  write data of each requester.
REQ-009 ACK0, ACK1  output  1 each  one-cycle completion pulse per requester.
REQ-010 LD  output  DW  registered data bus driven to the D pins of all latch words.
REQ-011 LE  output  NW  registered per-word latch enables (E pins), active-high, at most one bit set.
REQ-012 BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, SETUP, OPEN and HOLD.
REQ-014 Requester protocol: REQn, ADDRn and WDn SHALL be held stable until the cycle after ACKn; the block SHALL capture ADDR and WD on grant and SHALL NOT re-sample them afterwards.
REQ-015 IDLE: if any REQ is high, grant one requester, capture its ADDR to ADDR_Q and its WD to LD, and go to SETUP; otherwise stay in IDLE.
REQ-016 SETUP: LE all zero and LD stable (data setup to latch); go to OPEN the next cycle.
REQ-017 OPEN: LE[ADDR_Q] high for exactly one cycle, all other LE bits low, LD unchanged; go to HOLD.
REQ-018 HOLD: LE all zero and LD unchanged (data hold after latch closes); assert ACK of the granted requester for this cycle only; go to IDLE.
REQ-019 Each write SHALL take exactly 4 cycles from grant to IDLE re-entry; back-to-back grants SHALL NOT occur, and every LE pulse SHALL be separated by at least 3 cycles of all-zero LE.
REQ-020 Arbitration SHALL be round-robin using a 1-bit last-grant flag. When both REQs are high, grant the requester not granted last. When one REQ is high, grant it.
REQ-021 The last-grant flag SHALL update at grant time. Its reset value SHALL be 1, so requester 0 wins the first contention.
REQ-022 Out-of-range address (ADDR_Q >= NW): the write SHALL complete the full sequence with ACK, but no LE bit SHALL assert during OPEN.
REQ-023 A REQ that drops before grant SHALL be ignored; a REQ that drops after grant SHALL NOT abort the sequence.
REQ-024 LE, LD, ACK0, ACK1 and BUSY SHALL be driven directly from flops, with no combinational path from inputs to outputs.
REQ-025 ACK0 and ACK1 SHALL never be high in the same cycle.

Reset
REQ-026 On RN low, immediately and independent of CLK, the following SHALL clear: state to IDLE, LE = 0, LD = 0, ACK0 = ACK1 = 0, BUSY = 0, ADDR_Q = 0, last-grant flag = 1.
REQ-027 Reset asserted mid-sequence (including during OPEN) SHALL drop LE to zero asynchronously, and no ACK SHALL be issued for the aborted write.
REQ-028 The first grant SHALL be possible on the first rising CLK edge after RN deasserts.

Verification
REQ-029 Single write: REQ0=1, ADDR0=2, WD0=0xA5 -> LD=0xA5 in SETUP; LE=0x04 for one cycle; ACK0 in HOLD; 4 cycles total.
REQ-030 Contention after reset: REQ0=REQ1=1 held -> grant order 0,1,0,1; ACK0 and ACK1 alternate every 4 cycles and are never simultaneous.
REQ-031 Out of range: with NW=6, REQ1=1, ADDR1=7 -> LE stays 0 throughout; ACK1 pulses in the 4th cycle.
REQ-032 Reset during OPEN: RN low while LE=0x08 -> LE=0, BUSY=0 without a CLK edge; no ACK; after RN release the pending REQ is re-granted.
REQ-033 Hold check: REQ0 changes WD0 after grant -> LD keeps the captured value through HOLD; a latch model's Q equals the captured value.
REQ-034 Assertions on every cycle: LE is one-hot-or-zero; LE is high only in OPEN; LD is stable from SETUP through HOLD.
